dm_lsu: RTL and testbench
=========================

# dm_lsu

Parametrised data memory with an integrated load/store unit for the single-cycle/multi-cycle CPU datapath. It accepts byte, halfword and word accesses at byte addresses and performs little-endian lane placement on stores. Loads are sign- or zero-extended, and misaligned or illegal accesses are flagged without touching memory. Accesses use a request/ready handshake with a programmable load latency, so the CPU can stall on slow memory.

## Interface
- `AW`, default 7: word-address bits; depth = 2^AW 32-bit words, byte address width AW+2.
- `LOAD_LAT`, default 1: cycles from load acceptance to response; legal range 1..8.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: access request.
- `ready` out 1: block can accept a request this cycle.
- `we` in 1: 1 = store, 0 = load.
- `addr` in AW+2: byte address.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `uns` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `wdata` in 32: store data; byte uses [7:0], half uses [15:0].
- `resp_valid` out 1: one-cycle response pulse.
- `rdata` out 32: load result, valid with `resp_valid`.
- `err` out 1: misaligned/illegal flag, valid with `resp_valid`.

## Operation
- Handshake: a request is accepted at a rising edge where `req && ready`. The request fields are sampled only at acceptance.
- Alignment: byte is always legal. Halfword requires `addr[0]==0`. Word requires `addr[1:0]==0`. `size==11` is always an error.
- Word index = `addr[AW+1:2]`. Lane k = `addr[1:0]` selects bits [8k+7:8k]. Half lane h = `addr[1]` selects bits [16h+15:16h].
- Legal store: written at the acceptance edge. Only the addressed bytes change; the other bytes of the word are preserved.
- Legal load: memory word snapshot taken at acceptance. The selected lane is extended per `uns` to 32 bits. Word loads ignore `uns`.
- Error access: memory is not modified, `rdata`=0, `err`=1.
- FSM states:
  - IDLE: `ready`=1.
    - Accepted load with LOAD_LAT>1 goes to WAIT with cnt=LOAD_LAT-1.
    - Any other accepted request (store, error, or LOAD_LAT==1) goes to RESP.
  - WAIT: `ready`=0. cnt decrements each cycle. When cnt reaches 1, go to RESP.
  - RESP: `resp_valid`=1 and `ready`=1. A new request may be accepted in this cycle, following the IDLE transition rules; otherwise go to IDLE.
- `rdata`/`err` hold their value until the next response. They are undefined-free: after reset they are 0.
- Memory contents are not cleared by reset. The simulation model zero-initialises memory.

## Timing
- Reset values: state=IDLE, `ready`=1, `resp_valid`=0, `rdata`=0, `err`=0, cnt=0.
- Store and error latency: `resp_valid` is high in the cycle immediately after the acceptance edge. The write data is readable by a load accepted in that RESP cycle.
- Load latency: `resp_valid` is high exactly LOAD_LAT cycles after the acceptance edge. `ready` is low for LOAD_LAT-1 cycles between acceptance and response.
- Throughput:
  - LOAD_LAT=1: one access per cycle sustained, because back-to-back requests are accepted in RESP.
  - Otherwise: one load per LOAD_LAT cycles.
- `req` while `ready`=0 is ignored. It is not queued; the requester must hold `req`.
- Reset asserted mid-access (WAIT or RESP) immediately returns to IDLE with the reset output values. A pending load produces no response. A store already accepted remains written.
- Wrap-around: addresses have exactly AW+2 bits, so there is no out-of-range case.

## Test plan
- Word store then load, LOAD_LAT=1: store 0xDEADBEEF @0x10, load word @0x10 in the RESP cycle. Required: `rdata`=0xDEADBEEF, `err`=0, one response per cycle.
- Byte lanes: word 0x00000000 @0x20, store byte 0x80 @0x23, then load byte @0x23 with `uns`=0 and with `uns`=1. Required: word reads 0x80000000, then `rdata`=0xFFFFFF80, then 0x00000080.
- Halfword: word 0x11223344 @0x30, store half 0xABCD @0x32. Required: word reads 0xABCD3344, and half load @0x32 signed gives 0xFFFFABCD.
- Misaligned/illegal:
  - Word store 0x12345678 @0x41 → `err`=1, memory @0x40 unchanged.
  - Half load @0x43 → `err`=1, `rdata`=0.
  - size=11 → `err`=1.
- LOAD_LAT=4: load accepted at edge E0. Required: `ready` low for 3 cycles, `resp_valid` high only in cycle E0+4, and a `req` held during WAIT is accepted at the RESP edge.
- Reset in WAIT (LOAD_LAT=4): assert `rst` 2 cycles after acceptance. Required: no `resp_valid`, `ready`=1, `rdata`=0 and `err`=0 immediately on reset.

Source files
------------

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// dm_lsu : byte-addressable data memory with load/store unit and
//          request/ready handshake, programmable load latency.
// Revision: 1.0
// ============================================================================
module dm_lsu #(
  parameter int AW       = 7,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  output logic          ready_o,
  input  logic          we_i,
  input  logic [AW+1:0] addr_i,
  input  logic [1:0]    size_i,
  input  logic          uns_i,
  input  logic [31:0]   wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   rdata_o,
  output logic          err_o
);

  localparam int            DEPTH    = 2 ** AW;
  localparam int            CW       = 4;
  localparam logic [CW-1:0] LAT_M1   = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   pend_q, pend_d;
  logic          err_q, err_d;

  logic          w_accept;
  logic          w_misalign;
  logic          w_wr_en;
  logic [AW-1:0] w_widx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ldata;

  assign w_widx       = addr_i[AW+1:2];
  assign w_lane       = addr_i[1:0];
  assign ready_o      = (state_q != S_WAIT);
  assign w_accept     = req_i && ready_o;
  assign resp_valid_o = (state_q == S_RESP);
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

  // Store data is replicated across lanes so each byte lane simply picks its own slice.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wlanes   = wdata_i;
    case (size_i)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_misalign = w_lane[0];
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes   = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        w_misalign = |w_lane;
        w_be       = 4'b1111;
      end
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_wr_en = w_accept && we_i && !w_misalign;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
        if (w_wr_en && w_be[k]) begin
          mem_q[w_widx] <= w_wlanes[8*k +: 8];
        end
      end

      assign w_word[8*k +: 8] = mem_q[w_widx];
    end
  endgenerate

  always_comb begin
    w_byte  = w_word[{w_lane, 3'b000} +: 8];
    w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_ldata = w_word;
    case (size_i)
      2'b00:   w_ldata = uns_i ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ldata = uns_i ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ldata = w_word;
    endcase
  end

  // Multi-cycle loads park their snapshot in pend_q so rdata holds the previous
  // response until the new one is due.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    pend_d  = pend_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = pend_q;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          if (!we_i && !w_misalign && (LOAD_LAT > 1)) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
            pend_d  = w_ldata;
          end else begin
            state_d = S_RESP;
            err_d   = w_misalign;
            rdata_d = (!we_i && !w_misalign) ? w_ldata : 32'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// ============================================================================
// tb_dm_lsu : self-checking bench for dm_lsu, LOAD_LAT=1 and LOAD_LAT=4 instances.
// Revision: 1.0
// ============================================================================
module tb_dm_lsu;

  logic        clk;
  logic        rst;
  logic        req1, req4;
  logic        we, uns;
  logic [8:0]  addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        rdy1, rv1, er1;
  logic        rdy4, rv4, er4;
  logic [31:0] rd1, rd4;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mm [512];

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [23];

  dm_lsu #(.AW(7), .LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .ready_o(rdy1), .we_i(we),
    .addr_i(addr), .size_i(size), .uns_i(uns), .wdata_i(wdata),
    .resp_valid_o(rv1), .rdata_o(rd1), .err_o(er1)
  );

  dm_lsu #(.AW(7), .LOAD_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_i(req4), .ready_o(rdy4), .we_i(we),
    .addr_i(addr), .size_i(size), .uns_i(uns), .wdata_i(wdata),
    .resp_valid_o(rv4), .rdata_o(rd4), .err_o(er4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // One complete access on the selected instance; lat counts cycles to resp_valid.
  task automatic access(input bit s4, input logic w, input logic [8:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    we = w; addr = a; size = sz; uns = u; wdata = wd;
    if (s4) req4 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    req4 = 1'b0;
    lat  = 0;
    rd   = 32'hxxxxxxxx;
    er   = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (s4 ? rv4 : rv1) begin
        rd = s4 ? rd4 : rd1;
        er = s4 ? er4 : er1;
        break;
      end
    end
  endtask

  // Reference: byte array, little-endian assembly, arithmetic sign extension.
  task automatic model(input logic w, input logic [8:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_err, output bit is_load);
    int nb;
    logic [31:0] v;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    is_load = !w && !exp_err;
    exp_rd  = 32'd0;
    if (exp_err) return;
    nb = 1 << sz;
    if (w) begin
      for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | ({24'd0, mm[int'(a) + i]} << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
      exp_rd = v;
    end
  endtask

  initial begin
    logic [31:0] rd, exp_rd, wd;
    logic        er, exp_err, w, u;
    logic [8:0]  a;
    logic [1:0]  sz;
    bit          is_load, seen;
    int          lat, r;

    tbl[0]  = '{1'b1, 9'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 9'h020, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 9'h023, 2'b00, 1'b0, 32'h00000080, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 9'h020, 2'b10, 1'b1, 32'h0,        1'b1, 32'h80000000, 1'b0};
    tbl[5]  = '{1'b0, 9'h023, 2'b00, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    tbl[6]  = '{1'b0, 9'h023, 2'b00, 1'b1, 32'h0,        1'b1, 32'h00000080, 1'b0};
    tbl[7]  = '{1'b1, 9'h030, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 9'h032, 2'b01, 1'b0, 32'h0000ABCD, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 9'h030, 2'b10, 1'b0, 32'h0,        1'b1, 32'hABCD3344, 1'b0};
    tbl[10] = '{1'b0, 9'h032, 2'b01, 1'b0, 32'h0,        1'b1, 32'hFFFFABCD, 1'b0};
    tbl[11] = '{1'b0, 9'h032, 2'b01, 1'b1, 32'h0,        1'b1, 32'h0000ABCD, 1'b0};
    tbl[12] = '{1'b0, 9'h033, 2'b00, 1'b0, 32'h0,        1'b1, 32'hFFFFFFAB, 1'b0};
    tbl[13] = '{1'b0, 9'h031, 2'b00, 1'b0, 32'h0,        1'b1, 32'h00000033, 1'b0};
    tbl[14] = '{1'b1, 9'h040, 2'b10, 1'b0, 32'h55AA55AA, 1'b0, 32'h0,        1'b0};
    tbl[15] = '{1'b1, 9'h041, 2'b10, 1'b0, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 9'h040, 2'b10, 1'b0, 32'h0,        1'b1, 32'h55AA55AA, 1'b0};
    tbl[17] = '{1'b0, 9'h043, 2'b01, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[18] = '{1'b0, 9'h044, 2'b11, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[19] = '{1'b1, 9'h048, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
    tbl[20] = '{1'b0, 9'h048, 2'b10, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
    tbl[21] = '{1'b1, 9'h041, 2'b01, 1'b0, 32'h0000FFFF, 1'b1, 32'h0,        1'b1};
    tbl[22] = '{1'b0, 9'h040, 2'b10, 1'b0, 32'h0,        1'b1, 32'h55AA55AA, 1'b0};

    rst = 1'b1; req1 = 1'b0; req4 = 1'b0; we = 1'b0; uns = 1'b0;
    addr = '0; size = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready1", {31'd0, rdy1}, 32'd1);
    chk("reset resp1",  {31'd0, rv1},  32'd0);
    chk("reset rdata1", rd1, 32'd0);
    chk("reset err1",   {31'd0, er1},  32'd0);
    chk("reset ready4", {31'd0, rdy4}, 32'd1);
    chk("reset resp4",  {31'd0, rv4},  32'd0);
    chk("reset rdata4", rd4, 32'd0);
    chk("reset err4",   {31'd0, er4},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bring both memories to a known all-zero image.
    for (int i = 0; i < 128; i++) begin
      access(1'b0, 1'b1, 9'(i * 4), 2'b10, 1'b0, 32'd0, rd, er, lat);
      access(1'b1, 1'b1, 9'(i * 4), 2'b10, 1'b0, 32'd0, rd, er, lat);
    end
    for (int i = 0; i < 512; i++) mm[i] = 8'd0;

    // Randomized traffic in the upper half, checked against the byte-array model.
    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom % 2);
      r  = int'($urandom % 8);
      sz = (r < 7) ? 2'(r % 3) : 2'b11;
      a  = 9'h100 | 9'($urandom % 64);
      u  = 1'($urandom % 2);
      wd = $urandom;
      model(w, a, sz, u, wd, exp_rd, exp_err, is_load);
      for (int s = 0; s < 2; s++) begin
        access(s[0], w, a, sz, u, wd, rd, er, lat);
        chk(s ? "rand err4" : "rand err1", {31'd0, er}, {31'd0, exp_err});
        chk(s ? "rand lat4" : "rand lat1", lat, (s == 1 && is_load) ? 4 : 1);
        if (!w || exp_err) chk(s ? "rand rdata4" : "rand rdata1", rd, exp_rd);
      end
    end

    // Directed table on both latencies.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 23; i++) begin
        access(s[0], tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, rd, er, lat);
        chk($sformatf("tbl[%0d] s%0d err", i, s), {31'd0, er}, {31'd0, tbl[i].exp_err});
        chk($sformatf("tbl[%0d] s%0d lat", i, s), lat,
            (s == 1 && !tbl[i].we && !tbl[i].exp_err) ? 4 : 1);
        if (tbl[i].chk_rd) chk($sformatf("tbl[%0d] s%0d rdata", i, s), rd, tbl[i].exp_rd);
      end
    end

    // LOAD_LAT=1 back-to-back: store, then two loads accepted in consecutive RESP cycles.
    @(negedge clk);
    we = 1'b1; addr = 9'h014; size = 2'b10; uns = 1'b0; wdata = 32'hCAFEF00D; req1 = 1'b1;
    @(negedge clk);
    chk("b2b store resp", {31'd0, rv1}, 32'd1);
    chk("b2b store ready", {31'd0, rdy1}, 32'd1);
    chk("b2b store err", {31'd0, er1}, 32'd0);
    we = 1'b0;
    @(negedge clk);
    chk("b2b load1 resp", {31'd0, rv1}, 32'd1);
    chk("b2b load1 rdata", rd1, 32'hCAFEF00D);
    addr = 9'h015; size = 2'b00; uns = 1'b1;
    @(negedge clk);
    chk("b2b load2 resp", {31'd0, rv1}, 32'd1);
    chk("b2b load2 rdata", rd1, 32'h000000F0);
    req1 = 1'b0;
    @(negedge clk);
    chk("b2b idle resp", {31'd0, rv1}, 32'd0);

    // LOAD_LAT=4 timing with req held through WAIT.
    @(negedge clk);
    we = 1'b0; addr = 9'h010; size = 2'b10; uns = 1'b0; req4 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) addr = 9'h030;
      chk($sformatf("lat4 c%0d resp", i), {31'd0, rv4}, {31'd0, (i == 4 || i == 8)});
      chk($sformatf("lat4 c%0d ready", i), {31'd0, rdy4}, {31'd0, (i == 4 || i == 8)});
      if (i == 4) chk("lat4 rdata1", rd4, 32'hDEADBEEF);
      if (i == 8) begin
        chk("lat4 rdata2", rd4, 32'hABCD3344);
        req4 = 1'b0;
      end
    end
    @(negedge clk);
    chk("lat4 after resp", {31'd0, rv4}, 32'd0);

    // Reset two cycles into a LOAD_LAT=4 load.
    @(negedge clk);
    addr = 9'h010; size = 2'b10; req4 = 1'b1;
    @(posedge clk);
    #1 req4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst ready", {31'd0, rdy4}, 32'd1);
    chk("rst resp", {31'd0, rv4}, 32'd0);
    chk("rst rdata", rd4, 32'd0);
    chk("rst err", {31'd0, er4}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rv4) seen = 1'b1;
    end
    chk("rst no resp", {31'd0, seen}, 32'd0);
    access(1'b1, 1'b0, 9'h010, 2'b10, 1'b0, 32'd0, rd, er, lat);
    chk("post rst rdata", rd, 32'hDEADBEEF);
    chk("post rst lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
